// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, round count and byte/word helpers
package aes_pkg;
  typedef logic [0:15][7:0] state_t;
  typedef logic [0:3][7:0] word_t;
  localparam int NR_128 = 10;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic word_t rot_word(input word_t w);
    return {w[1], w[2], w[3], w[0]};
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box lookup
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_s = SBOX[i_a];
endmodule

// File: rtl/aes_add_round_key_stage.sv
// aes_add_round_key_stage: registered AddRoundKey with on-the-fly AES-128 key schedule
module aes_add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [0:15][7:0] key_i,
  input  logic             key_load_i,
  input  logic [0:15][7:0] state_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [0:15][7:0] state_o,
  output logic [3:0]       round_o,
  output logic             valid_o,
  input  logic             ready_i
);
  logic [0:15][7:0] r_cipher_key, r_round_key, r_state;
  logic [3:0] r_cnt, r_round;
  logic [7:0] r_rcon;
  logic r_key_valid, r_valid;
  word_t w_rot, w_sub, w_t, w_k0, w_k1, w_k2, w_k3;
  logic w_acc, w_wrap;
  assign w_rot = rot_word(r_round_key[12:15]);
  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (.i_a(w_rot[i]), .o_s(w_sub[i]));
  end
  // each word folds in all previous ones so no signal feeds back on itself
  assign w_t  = w_sub ^ {r_rcon, 24'h0};
  assign w_k0 = r_round_key[0:3] ^ w_t;
  assign w_k1 = r_round_key[4:7] ^ w_k0;
  assign w_k2 = r_round_key[8:11] ^ w_k1;
  assign w_k3 = r_round_key[12:15] ^ w_k2;
  assign ready_o = r_key_valid && !key_load_i && (!r_valid || ready_i);
  assign w_acc = valid_i && ready_o;
  assign w_wrap = r_cnt == 4'(NR);
  assign state_o = r_state;
  assign round_o = r_round;
  assign valid_o = r_valid;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cipher_key <= '0;
      r_round_key <= '0;
      r_state <= '0;
      r_cnt <= '0;
      r_round <= '0;
      r_rcon <= '0;
      r_key_valid <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_state <= state_i ^ r_round_key;
        r_round <= r_cnt;
        r_valid <= 1'b1;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
      if (key_load_i) begin
        r_cipher_key <= key_i;
        r_round_key <= key_i;
        r_cnt <= '0;
        r_rcon <= 8'h01;
        r_key_valid <= 1'b1;
      end else if (w_acc) begin
        r_round_key <= w_wrap ? r_cipher_key : {w_k0, w_k1, w_k2, w_k3};
        r_cnt <= w_wrap ? 4'd0 : r_cnt + 4'd1;
        r_rcon <= w_wrap ? 8'h01 : xtime(r_rcon);
      end
    end
  end
endmodule
